// File: rtl/demux_pkg.sv
// Shared definitions for param_stream_demux.
// Holds the FSM state encoding used by the demux top and visible on its
// debug state output.
package demux_pkg;

  typedef logic [1:0] state_t;

  // No packet open; the next accepted beat is a first beat and samples in_sel.
  localparam logic [1:0] ST_IDLE = 2'd0;
  // Packet open and locked to cur_sel until its last beat.
  localparam logic [1:0] ST_PKT  = 2'd1;
  // Packet open to an out-of-range destination; beats are swallowed.
  localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/param_stream_demux_if.sv
// Bus bundle for param_stream_demux: one input stream plus N output channels.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// where valid && ready. A source holding valid high keeps its data/last
// stable until the transfer. A ready may depend combinationally on state and
// on the far side's ready, but never on the same side's valid.
//
// Signals:
//   in_valid/in_ready/in_data/in_last/in_sel  input stream (in_sel used on first beat)
//   out_valid[N]/out_ready[N]                  per-channel handshake
//   out_data[N*M]                              channel k at [(k+1)*M-1:k*M]
//   out_last[N]                                per-channel last flag
// Modports: slave = demux view, master = stream source / channel sinks view.
interface param_stream_demux_if #(
  parameter int N         = 16,
  parameter int SEL_LINES = 4,
  parameter int M         = 4
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [M-1:0]         in_data;
  logic                 in_last;
  logic [SEL_LINES-1:0] in_sel;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*M-1:0]       out_data;
  logic [N-1:0]         out_last;

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// Accepts a beat when empty or when the held beat drains in the same cycle,
// so a continuously-ready sink sees one beat per clock.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       load side (in_ready = slot free)
//   in_data[M], in_last     beat to store
//   out_valid/out_ready     channel side handshake
//   out_data[M], out_last   held beat, stable while out_valid && !out_ready
module demux_slot #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_last
);

  // Free when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/param_stream_demux.sv
// Routes one valid/ready input stream to one of N output channels.
// The destination is taken from in_sel on a packet's first beat and held
// until the packet's last beat. Each channel has its own 1-entry register, so
// a stalled channel only blocks the input stream while it is the target;
// other channels keep draining. Packets addressed to in_sel >= N are
// swallowed whole and counted.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus (slave)     input stream + N output channels (see param_stream_demux_if)
//   drop_pulse      one-cycle pulse for each dropped packet
//   drop_count      saturating count of dropped packets
//   dbg_state       current FSM state (demux_pkg ST_* encoding)
module param_stream_demux
  import demux_pkg::*;
#(
  parameter int N         = 16,
  parameter int SEL_LINES = 4,
  parameter int M         = 4,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  param_stream_demux_if.slave bus,
  output logic                drop_pulse,
  output logic [CNT_W-1:0]    drop_count,
  output logic [1:0]          dbg_state
);

  // N held one bit wider than in_sel so N == 2**SEL_LINES compares correctly.
  localparam logic [SEL_LINES:0] N_SEL = (SEL_LINES + 1)'(N);

  state_t               state;
  logic [SEL_LINES-1:0] cur_sel;
  logic [SEL_LINES-1:0] tgt;
  logic                 sel_in_range;
  logic                 discard;
  logic                 tgt_free;
  logic                 accept;
  logic                 drop_start;
  logic [N-1:0]         slot_ready;
  logic [N-1:0]         load;
  logic [N-1:0]         slot_valid;
  logic [N-1:0]         slot_last;
  logic [N*M-1:0]       slot_data;

  assign sel_in_range = {1'b0, bus.in_sel} < N_SEL;
  assign tgt          = (state == ST_IDLE) ? bus.in_sel : cur_sel;

  // Beats that will be swallowed: body of a dropped packet, or the first
  // beat of a packet with an out-of-range destination.
  assign discard = (state == ST_DROP) || ((state == ST_IDLE) && !sel_in_range);

  // Compare-select rather than slot_ready[tgt] so an out-of-range tgt never
  // indexes past the slot array.
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (tgt == SEL_LINES'(k)) tgt_free = slot_ready[k];
    end
  end

  // Depends on state, in_sel and out_ready only; never on in_valid.
  assign bus.in_ready = discard || tgt_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drop_start   = accept && (state == ST_IDLE) && !sel_in_range;

  // One-hot load enable: at most one channel can be written per cycle.
  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && !discard && (tgt == SEL_LINES'(k));
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.M(M)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (load[k]),
      .in_ready  (slot_ready[k]),
      .in_data   (bus.in_data),
      .in_last   (bus.in_last),
      .out_valid (slot_valid[k]),
      .out_ready (bus.out_ready[k]),
      .out_data  (slot_data[k*M +: M]),
      .out_last  (slot_last[k])
    );
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign bus.out_last  = slot_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_sel    <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop_start;
      if (drop_start && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          // Single-beat packets (in_last on the first beat) never leave IDLE.
          if (accept && !bus.in_last) begin
            if (sel_in_range) begin
              state   <= ST_PKT;
              cur_sel <= bus.in_sel;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PKT, ST_DROP: begin
          if (accept && bus.in_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_param_stream_demux.sv
// Bench for param_stream_demux. Two instances share one driver: dut_a with
// N=16, CNT_W=8 and dut_b with N=12, CNT_W=2 (out-of-range destinations and
// counter saturation). use_b selects which instance the driver and monitor
// talk to; the idle instance sees in_valid=0.
module tb_param_stream_demux;

  localparam int M  = 4;
  localparam int SL = 4;
  localparam int NA = 16;
  localparam int NB = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        use_b;
  logic        in_valid;
  logic        in_last;
  logic [3:0]  in_data;
  logic [3:0]  in_sel;
  logic [15:0] out_ready;

  param_stream_demux_if #(.N(NA), .SEL_LINES(SL), .M(M)) bus_a ();
  param_stream_demux_if #(.N(NB), .SEL_LINES(SL), .M(M)) bus_b ();

  logic       pulse_a, pulse_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] st_a, st_b;

  param_stream_demux #(.N(NA), .SEL_LINES(SL), .M(M), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .drop_pulse(pulse_a), .drop_count(cnt_a), .dbg_state(st_a)
  );

  param_stream_demux #(.N(NB), .SEL_LINES(SL), .M(M), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .drop_pulse(pulse_b), .drop_count(cnt_b), .dbg_state(st_b)
  );

  assign bus_a.in_valid  = in_valid && !use_b;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.in_sel    = in_sel;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid && use_b;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.in_sel    = in_sel;
  assign bus_b.out_ready = out_ready[11:0];

  logic        in_ready;
  logic [15:0] out_valid;
  logic [63:0] out_data;
  logic [15:0] out_last;
  logic        drop_pulse;
  logic [7:0]  drop_count;
  logic [1:0]  dut_state;

  assign in_ready   = use_b ? bus_b.in_ready : bus_a.in_ready;
  assign out_valid  = use_b ? {4'b0, bus_b.out_valid} : bus_a.out_valid;
  assign out_data   = use_b ? {16'b0, bus_b.out_data} : bus_a.out_data;
  assign out_last   = use_b ? {4'b0, bus_b.out_last} : bus_a.out_last;
  assign drop_pulse = use_b ? pulse_b : pulse_a;
  assign drop_count = use_b ? {6'b0, cnt_b} : cnt_a;
  assign dut_state  = use_b ? st_b : st_a;

  // ---------------- reference model / scoreboard state ----------------
  logic [4:0] exp_q [16][$];   // per channel: {last, data}
  int open_dest   = -1;        // -1: no packet open, -2: packet being dropped
  int drops       = 0;
  int cyc         = 0;
  int drop_cyc    = -1;        // cycle whose edge started a drop
  int lat_cyc     = -1;        // cycle whose edge accepted the latest beat
  int lat_dest    = -1;        // channel of that beat, -1 if swallowed
  int checks      = 0;
  int errors      = 0;
  int stalls      = 0;
  int pulses_seen = 0;
  logic [15:0] valid_seen = '0;
  logic        rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nch();
    return use_b ? NB : NA;
  endfunction

  function automatic int cmax();
    return use_b ? 3 : 255;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level routing rule: the first beat of a packet picks the
  // destination, later beats follow it, out-of-range packets vanish.
  task automatic model_accept(input int sel, input logic [3:0] data, input logic last);
    lat_cyc  = cyc;
    lat_dest = -1;
    if (open_dest == -1) begin
      if (sel >= nch()) begin
        drops++;
        drop_cyc = cyc;
        if (!last) open_dest = -2;
      end else begin
        exp_q[sel].push_back({last, data});
        lat_dest = sel;
        if (!last) open_dest = sel;
      end
    end else if (open_dest == -2) begin
      if (last) open_dest = -1;
    end else begin
      exp_q[open_dest].push_back({last, data});
      lat_dest = open_dest;
      if (last) open_dest = -1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1. Leaves in_valid high so beats can go
  // back to back; idle() drops it.
  task automatic send_beat(input logic [3:0] sel, input logic [3:0] data, input logic last);
    int   waited;
    logic acc;
    waited   = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        waited++;
        stalls++;
      end
    end
    if (acc) begin
      @(posedge clk);
      #1;
      model_accept(int'(sel), data, last);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance (sel=%0d)", sel);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    use_b    = b;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) exp_q[k].delete();
    open_dest   = -1;
    drops       = 0;
    drop_cyc    = -1;
    lat_cyc     = -1;
    pulses_seen = 0;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", out_data, 64'(0));
    check("reset_out_last", 64'(out_last), 64'(0));
    check("reset_drop_pulse", 64'(drop_pulse), 64'(0));
    check("reset_drop_count", 64'(drop_count), 64'(0));
    check("reset_state", 64'(dut_state), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int pkts);
    int len;
    rand_ready = 1'b1;
    repeat (pkts) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), b == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_ready = 1'b0;
    out_ready  = '1;
    idle(6);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 16'($urandom);
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] prev_valid, prev_ready, prev_last, rise_ok;
  logic [63:0] prev_data;
  logic [4:0]  exp_e;
  int          exp_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = '0;
      prev_ready = '0;
      prev_last  = '0;
      prev_data  = '0;
    end else begin
      exp_cnt = (drops > cmax()) ? cmax() : drops;
      check("drop_count", 64'(drop_count), 64'(exp_cnt));
      check("drop_pulse", 64'(drop_pulse), 64'(drop_cyc == cyc));
      if (drop_pulse) pulses_seen++;

      rise_ok = '0;
      if (lat_cyc == cyc && lat_dest >= 0) begin
        rise_ok[lat_dest] = 1'b1;
        check($sformatf("latency_ch%0d", lat_dest), 64'(out_valid[lat_dest]), 64'(1));
      end
      check("unexpected_valid_rise", 64'(out_valid & ~prev_valid & ~rise_ok), 64'(0));

      for (int k = 0; k < 16; k++) begin
        if (prev_valid[k] && !prev_ready[k]) begin
          check($sformatf("hold_valid_ch%0d", k), 64'(out_valid[k]), 64'(1));
          check($sformatf("hold_beat_ch%0d", k), 64'({out_last[k], out_data[k*4 +: 4]}),
                64'({prev_last[k], prev_data[k*4 +: 4]}));
        end
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_ch%0d: got beat 0x%0h expected no beat", k,
                     {out_last[k], out_data[k*4 +: 4]});
          end else begin
            exp_e = exp_q[k].pop_front();
            check($sformatf("sb_ch%0d", k), 64'({out_last[k], out_data[k*4 +: 4]}), 64'(exp_e));
          end
        end
      end

      valid_seen = valid_seen | out_valid;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_last  = out_last;
      prev_data  = out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion before 2ms");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  int rem;

  initial begin
    rst_n     = 1'b0;
    use_b     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '1;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Reset mid-packet: the open packet to ch3 must be forgotten.
    send_beat(4'd3, 4'h1, 1'b0);
    send_beat(4'd3, 4'h2, 1'b0);
    do_reset(1'b0);
    send_beat(4'd5, 4'hA, 1'b1);
    @(negedge clk);
    check("post_reset_only_ch5", 64'(out_valid), 64'(16'h0020));
    check("post_reset_ch5_data", 64'(out_data[23:20]), 64'(4'hA));
    idle(2);

    // Packet lock: in_sel changes mid-packet are ignored.
    valid_seen = '0;
    send_beat(4'd2, 4'h3, 1'b0);
    send_beat(4'd7, 4'h4, 1'b0);
    send_beat(4'd7, 4'h5, 1'b1);
    idle(3);
    check("lock_only_ch2", 64'(valid_seen), 64'(16'h0004));

    // Throughput: one single-beat packet per channel, no stalls.
    stalls = 0;
    for (int k = 0; k < 16; k++) send_beat(4'(k), 4'(k), 1'b1);
    idle(3);
    check("throughput_stalls", 64'(stalls), 64'(0));

    // Backpressure on ch4: second beat waits until out_ready[4] returns.
    out_ready[4] = 1'b0;
    send_beat(4'd4, 4'h6, 1'b0);
    stalls = 0;
    fork
      send_beat(4'd9, 4'h7, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready[4] = 1'b1;
      end
    join
    check("backpressure_stalls", 64'(stalls), 64'(3));
    idle(3);

    random_phase(60);
    rem = 0;
    for (int k = 0; k < 16; k++) rem += exp_q[k].size();
    check("drain_a_empty", 64'(rem), 64'(0));

    // Drop on N=12: sel 13 packet vanishes, next packet routes normally.
    do_reset(1'b1);
    stalls     = 0;
    valid_seen = '0;
    send_beat(4'd13, 4'h1, 1'b0);
    send_beat(4'd1, 4'h2, 1'b0);
    send_beat(4'd3, 4'h3, 1'b1);
    idle(3);
    check("drop_no_stall", 64'(stalls), 64'(0));
    check("drop_no_valid", 64'(valid_seen), 64'(0));
    check("drop_one_pulse", 64'(pulses_seen), 64'(1));
    check("drop_count_1", 64'(drop_count), 64'(1));
    send_beat(4'd1, 4'hB, 1'b0);
    send_beat(4'd13, 4'hC, 1'b1);
    idle(3);
    check("after_drop_ch1", 64'(valid_seen), 64'(16'h0002));

    // Saturation on CNT_W=2.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send_beat(4'(12 + (i % 4)), 4'(i), 1'b1);
    idle(3);
    check("sat_count", 64'(drop_count), 64'(3));
    check("sat_pulses", 64'(pulses_seen), 64'(5));

    random_phase(60);
    rem = 0;
    for (int k = 0; k < 16; k++) rem += exp_q[k].size();
    check("drain_b_empty", 64'(rem), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
